// File: rtl/game_scoreboard_pkg.sv
// ============================================================================
// game_scoreboard_pkg : shared FSM state and `who` encodings for the scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

package game_scoreboard_pkg;

   typedef enum logic [0:0] {
      SB_PLAY = 1'b0,
      SB_HOLD = 1'b1
   } sb_state_e;

   localparam logic [1:0] WHO_NONE = 2'b00;
   localparam logic [1:0] WHO_DOWN = 2'b01;
   localparam logic [1:0] WHO_UP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/rise_detect.sv
// ============================================================================
// rise_detect : registered rising-edge detector with a configurable reset level
// Rev 1.0
// ============================================================================
`default_nettype none

module rise_detect #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);

   logic level_q;
   logic level_d;

   always_comb begin
      level_d = d;
   end

   // Resetting to 1 masks a level that is already high when reset releases.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= RST_VAL;
      end else begin
         level_q <= level_d;
      end
   end

   assign rise = d & ~level_q;

endmodule

`default_nettype wire

// File: rtl/game_scoreboard.sv
// ============================================================================
// game_scoreboard : credits rounds from counter GAMEOVER events and hands a
//                   best-of match result downstream on a valid/ready port
// Rev 1.0
// ============================================================================
`default_nettype none

module game_scoreboard
   import game_scoreboard_pkg::*;
#(
   parameter int ROUNDS_TO_WIN = 3,
   parameter int SCORE_WIDTH   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   gameover,
   input  logic [1:0]             who,
   input  logic                   winner,
   input  logic                   loser,
   output logic [SCORE_WIDTH-1:0] score_up,
   output logic [SCORE_WIDTH-1:0] score_down,
   output logic [SCORE_WIDTH-1:0] round_no,
   output logic [SCORE_WIDTH-1:0] max_hits,
   output logic [SCORE_WIDTH-1:0] min_hits,
   output logic                   round_done,
   output logic                   match_valid,
   output logic                   match_winner,
   input  logic                   match_ready,
   output logic                   proto_err
);

   localparam logic [SCORE_WIDTH-1:0] C_RTW = SCORE_WIDTH'(ROUNDS_TO_WIN);
   localparam logic [SCORE_WIDTH-1:0] C_MAX = '1;

   logic go_rise;
   logic win_rise;
   logic lose_rise;

   rise_detect #(.RST_VAL(1'b1)) u_go_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (gameover),
      .rise (go_rise)
   );

   rise_detect #(.RST_VAL(1'b1)) u_win_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (winner),
      .rise (win_rise)
   );

   rise_detect #(.RST_VAL(1'b1)) u_lose_rise (
      .clk  (clk),
      .rst  (rst),
      .d    (loser),
      .rise (lose_rise)
   );

   sb_state_e              state_q, state_d;
   logic [SCORE_WIDTH-1:0] score_up_q, score_up_d;
   logic [SCORE_WIDTH-1:0] score_down_q, score_down_d;
   logic [SCORE_WIDTH-1:0] round_no_q, round_no_d;
   logic [SCORE_WIDTH-1:0] max_hits_q, max_hits_d;
   logic [SCORE_WIDTH-1:0] min_hits_q, min_hits_d;
   logic                   round_done_q, round_done_d;
   logic                   match_valid_q, match_valid_d;
   logic                   match_winner_q, match_winner_d;
   logic                   proto_err_q, proto_err_d;

   always_comb begin
      state_d        = state_q;
      score_up_d     = score_up_q;
      score_down_d   = score_down_q;
      round_no_d     = round_no_q;
      max_hits_d     = max_hits_q;
      min_hits_d     = min_hits_q;
      round_done_d   = 1'b0;
      match_valid_d  = match_valid_q;
      match_winner_d = match_winner_q;
      proto_err_d    = proto_err_q;

      case (state_q)
         SB_PLAY: begin
            if (go_rise) begin
               // The round boundary clear takes priority over a coincident hit.
               max_hits_d = '0;
               min_hits_d = '0;
               if (who == WHO_UP || who == WHO_DOWN) begin
                  round_done_d = 1'b1;
                  if (round_no_q != C_MAX) begin
                     round_no_d = round_no_q + 1'b1;
                  end
                  if (who == WHO_UP) begin
                     score_up_d = score_up_q + 1'b1;
                     if (score_up_d == C_RTW) begin
                        state_d        = SB_HOLD;
                        match_valid_d  = 1'b1;
                        match_winner_d = 1'b1;
                     end
                  end else begin
                     score_down_d = score_down_q + 1'b1;
                     if (score_down_d == C_RTW) begin
                        state_d        = SB_HOLD;
                        match_valid_d  = 1'b1;
                        match_winner_d = 1'b0;
                     end
                  end
               end else begin
                  proto_err_d = 1'b1;
               end
            end else begin
               if (win_rise && max_hits_q != C_MAX) begin
                  max_hits_d = max_hits_q + 1'b1;
               end
               if (lose_rise && min_hits_q != C_MAX) begin
                  min_hits_d = min_hits_q + 1'b1;
               end
            end
         end

         SB_HOLD: begin
            // No round can be credited while a result is pending or being taken.
            if (go_rise) begin
               proto_err_d = 1'b1;
            end
            if (match_valid_q && match_ready) begin
               state_d       = SB_PLAY;
               score_up_d    = '0;
               score_down_d  = '0;
               round_no_d    = '0;
               max_hits_d    = '0;
               min_hits_d    = '0;
               match_valid_d = 1'b0;
            end
         end

         default: begin
            state_d = SB_PLAY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= SB_PLAY;
         score_up_q     <= '0;
         score_down_q   <= '0;
         round_no_q     <= '0;
         max_hits_q     <= '0;
         min_hits_q     <= '0;
         round_done_q   <= 1'b0;
         match_valid_q  <= 1'b0;
         match_winner_q <= 1'b0;
         proto_err_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         score_up_q     <= score_up_d;
         score_down_q   <= score_down_d;
         round_no_q     <= round_no_d;
         max_hits_q     <= max_hits_d;
         min_hits_q     <= min_hits_d;
         round_done_q   <= round_done_d;
         match_valid_q  <= match_valid_d;
         match_winner_q <= match_winner_d;
         proto_err_q    <= proto_err_d;
      end
   end

   assign score_up     = score_up_q;
   assign score_down   = score_down_q;
   assign round_no     = round_no_q;
   assign max_hits     = max_hits_q;
   assign min_hits     = min_hits_q;
   assign round_done   = round_done_q;
   assign match_valid  = match_valid_q;
   assign match_winner = match_winner_q;
   assign proto_err    = proto_err_q;

endmodule

`default_nettype wire
